quad_decoder: RTL and testbench
===============================

# quad_decoder

Quadrature encoder front end: it synchronises and glitch-filters two asynchronous encoder channels (A/B) and decodes Gray-code transitions into a single-cycle step pulse plus a direction level. It sits directly upstream of the up/down position counter. `step` drives the counter's `en` and `dir` drives its `up_down` (1 = up), so every legal encoder edge moves the count by exactly one. Illegal double-bit transitions are flagged and never produce a step.

## Interface
- `FILT_CYC`, default 4: consecutive synchronised samples a new A/B value must hold before acceptance. Legal range is 1..255.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low; clock `clk`.
- `a_in`  input  1  encoder channel A, asynchronous to `clk`.
- `b_in`  input  1  encoder channel B, asynchronous to `clk`.
- `enable`  input  1  step gating. When 0, `step` is held at 0 and the filter keeps tracking.
- `err_clr`  input  1  synchronous clear of `err`.
- `step`  output  1  one-cycle pulse per accepted legal transition. Feeds counter `en`.
- `dir`  output  1  direction of the last legal transition: 1 = up (forward), 0 = down. Feeds counter `up_down`.
- `err`  output  1  sticky illegal-transition flag.

## Operation
- **Synchroniser:** a 2-FF chain per channel, `s1` then `s2`. Both channels travel as the pair `ab = {a, b}`.
- **Filter:**
  - A counter tracks how long the current `s2` pair value has been constant.
  - The counter restarts at 1 whenever `s2` differs from its value at the previous edge.
  - `filt` loads value V at the edge where V has been sampled on `s2` for `FILT_CYC` consecutive edges and V ≠ `filt`.
  - Any shorter excursion is discarded with no effect.
- **FSM**, 2 states:
  - **INIT**, the reset state: the first filter acceptance loads `filt` with no step and no error, then the FSM moves to TRACK. While in INIT the acceptance condition is V ≠ the reset value OR a full `FILT_CYC` window elapsed, so a pair idle at 00 also exits INIT.
  - **TRACK:** each acceptance compares the old `filt` with the new one.
- **Decode (TRACK):**
  - Forward sequence 00→01→11→10→00: `step` = 1 (if `enable`), `dir` ← 1.
  - Reverse sequence 00→10→11→01→00: `step` = 1 (if `enable`), `dir` ← 0.
  - Both bits changed (00↔11, 01↔10): `err` ← 1, no step, `dir` unchanged, and `filt` still takes the new value.
- **Outputs:**
  - `step` and `dir` are registered and updated together, so `dir` is valid in the same cycle `step` is high.
  - `dir` holds its value between steps.
- **`err`:** set on any illegal transition and cleared by `err_clr`. If both occur on the same edge, set wins.
- **`enable`:**
  - When 0, `dir` still updates and `err` still sets; only `step` is suppressed.
  - Re-enabling never produces a retroactive step.
- **Reset values:** `step` = 0, `dir` = 1, `err` = 0, `s1`/`s2`/`filt` = 00, filter counter = 0, FSM = INIT.
- **Reset mid-operation:**
  - Assertion forces all reset values immediately, with no step pulse.
  - After release the FSM is back in INIT.

## Timing
- With `a_in`/`b_in` changed and stable before edge t0:
  - `s1` captures at t0 and `s2` at t0+1.
  - `filt` updates at t0+1+`FILT_CYC`.
  - `step`/`dir` update at t0+2+`FILT_CYC`, and `step` is high for exactly that one cycle.
- Total latency is `FILT_CYC`+2 edges; with the default (4), 6 edges.
- Max step rate is one per `FILT_CYC` cycles. Encoder edges spaced closer than `FILT_CYC` cycles are filtered out, which is by design.
- `step` is never high on two consecutive cycles when `FILT_CYC` ≥ 2.
- Throughput at `FILT_CYC` = 1: one step per cycle is possible.

## Test plan
- **Reset/INIT:** reset with A/B = 11, release, hold 20 cycles → `filt` = 11, `step` never pulses, `err` = 0, `dir` = 1.
- **Forward:** from 00, drive 01, 11, 10, 00, each held 10 cycles, `enable` = 1 → exactly 4 single-cycle `step` pulses with `dir` = 1, each 6 edges after its input change. The downstream counter advances 0→4.
- **Reverse then glitch:**
  - From 00, drive 10, 11, each held 10 cycles → 2 pulses with `dir` = 0.
  - Then toggle A for 3 cycles only → no step, `filt` unchanged.
- **Illegal and clear:**
  - In TRACK at 00, drive 11 for 10 cycles → `err` = 1, no step, `dir` unchanged.
  - Assert `err_clr` on the same edge as a second illegal transition → `err` stays 1.
  - `err_clr` alone → `err` = 0.
- **Enable gating:** `enable` = 0, drive 00→01 → no step, `dir` = 1. Raise `enable` → no pulse. The next legal 01→11 gives 1 pulse.
- **Reset mid-operation:** assert `rst_n` = 0 in the cycle `step` would pulse → `step` stays 0, all outputs at reset values. After release, the first acceptance produces no step.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: 2-FF synchroniser, hold-time glitch filter and Gray-code
// decoder producing a one-cycle step pulse, a direction level and a sticky error flag.
module quad_decoder #(
  parameter int unsigned FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_in,
  input  logic b_in,
  input  logic enable,
  input  logic err_clr,
  output logic step,
  output logic dir,
  output logic err
);

  typedef enum logic {StInit, StTrack} state_e;

  localparam logic [7:0] FiltCyc = 8'(FILT_CYC);

  state_e     r_state, w_state_next;
  logic [1:0] r_s1, r_s2, r_last, r_filt, r_old;
  logic [7:0] r_cnt, w_cnt_now;
  logic       r_pend, r_step, r_dir, r_err;
  logic       w_accept, w_illegal;
  logic [1:0] w_fwd_of;

  // Run length of the current s2 value, counting the edge being evaluated.
  always_comb begin
    w_cnt_now = r_cnt;
    if (r_s2 != r_last) begin
      w_cnt_now = 8'd1;
    end else if (r_cnt != 8'hFF) begin
      w_cnt_now = r_cnt + 8'd1;
    end
  end

  // INIT accepts any settled value so an encoder idling at 00 still leaves INIT.
  assign w_accept = (w_cnt_now >= FiltCyc) && ((r_state == StInit) || (r_s2 != r_filt));

  always_comb begin
    w_state_next = r_state;
    if (r_state == StInit && w_accept) begin
      w_state_next = StTrack;
    end
  end

  always_comb begin
    w_fwd_of = 2'b00;
    unique case (r_old)
      2'b00: w_fwd_of = 2'b01;
      2'b01: w_fwd_of = 2'b11;
      2'b11: w_fwd_of = 2'b10;
      2'b10: w_fwd_of = 2'b00;
      default: w_fwd_of = 2'b00;
    endcase
  end

  assign w_illegal = ((r_old ^ r_filt) == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 2'b00;
      r_s2   <= 2'b00;
      r_last <= 2'b00;
      r_cnt  <= 8'd0;
      r_filt <= 2'b00;
      r_old  <= 2'b00;
      r_pend <= 1'b0;
      r_step <= 1'b0;
      r_dir  <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      r_s1   <= {a_in, b_in};
      r_s2   <= r_s1;
      r_last <= r_s2;
      r_cnt  <= w_cnt_now;
      r_old  <= r_filt;
      if (w_accept) begin
        r_filt <= r_s2;
      end
      // Decode happens one edge after acceptance, comparing the previous and new filt.
      r_pend <= w_accept && (r_state == StTrack);
      r_step <= r_pend && !w_illegal && enable;
      if (r_pend && !w_illegal) begin
        r_dir <= (r_filt == w_fwd_of);
      end
      r_err  <= (r_pend && w_illegal) || (r_err && !err_clr);
    end
  end

  assign step = r_step;
  assign dir  = r_dir;
  assign err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: expected step pulses (direction and cycle) are queued by
// the stimulus and retired by an independent monitor that watches the step output.
module tb_quad_decoder;

  typedef struct {
    logic dir;
    int   cyc;
  } exp_t;

  logic clk, rst_n, a_in, b_in, enable, err_clr;
  logic step, dir, err;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pos      = 0;
  exp_t exp_q[$];

  quad_decoder #(.FILT_CYC(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_in    (a_in),
    .b_in    (b_in),
    .enable  (enable),
    .err_clr (err_clr),
    .step    (step),
    .dir     (dir),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Inputs change just after a falling edge; the pulse lands 7 rising edges later.
  task automatic drive(input logic [1:0] ab, input int hold, input bit exp_step,
                       input bit exp_dir);
    exp_t e;
    a_in = ab[1];
    b_in = ab[0];
    if (exp_step) begin
      e.dir = exp_dir;
      e.cyc = cyc + 7;
      exp_q.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  // Monitor: every step pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (step !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step actual=%b required=0 (cycle %0d)", step, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("step_dir", int'(dir), int'(e.dir));
        check("step_cycle", cyc, e.cyc);
      end
      pos = dir ? pos + 1 : pos - 1;
    end
  end

  initial begin
    rst_n   = 1'b0;
    a_in    = 1'b1;
    b_in    = 1'b1;
    enable  = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_step", int'(step), 0);
    check("reset_dir", int'(dir), 1);
    check("reset_err", int'(err), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("init_err", int'(err), 0);
    check("init_dir", int'(dir), 1);

    // From INIT value 11 walk back to 00, then a full forward cycle.
    drive(2'b01, 10, 1, 0);
    drive(2'b00, 10, 1, 0);
    check("pos_at_00", pos, -2);
    drive(2'b01, 10, 1, 1);
    drive(2'b11, 10, 1, 1);
    drive(2'b10, 10, 1, 1);
    drive(2'b00, 10, 1, 1);
    check("pos_after_fwd", pos, 2);

    // Reverse pair, then a 3-cycle glitch on A that must be swallowed.
    drive(2'b10, 10, 1, 0);
    drive(2'b11, 10, 1, 0);
    drive(2'b01, 3, 0, 0);
    drive(2'b11, 10, 0, 0);
    drive(2'b01, 10, 1, 0);
    drive(2'b00, 10, 1, 0);
    check("pos_after_rev", pos, -2);

    // Illegal 00->11, then 11->00 with err_clr on the same edge as the set.
    drive(2'b11, 10, 0, 0);
    check("illegal_err", int'(err), 1);
    check("illegal_dir", int'(dir), 0);
    drive(2'b00, 6, 0, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("set_beats_clr", int'(err), 1);
    repeat (4) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", int'(err), 0);
    check("dir_after_illegal", int'(dir), 0);

    // Gated transition still updates dir; re-enabling gives no late pulse.
    enable = 1'b0;
    drive(2'b01, 10, 0, 0);
    check("gated_dir", int'(dir), 1);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    drive(2'b11, 10, 1, 1);
    check("gated_err", int'(err), 0);

    // Reset lands in the cycle the 01->00 pulse would have appeared.
    drive(2'b01, 10, 1, 0);
    drive(2'b00, 6, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_step", int'(step), 0);
    check("midreset_dir", int'(dir), 1);
    check("midreset_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postreset_dir", int'(dir), 1);
    drive(2'b01, 10, 1, 1);

    repeat (5) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
